// File: rtl/wb_burst_master.sv
// Wishbone B3 burst initiator: moves one BURST_LEN-word line per start request.
// Optional ack watchdog with ABORT state is compiled in by WB_BURST_MASTER_TIMEOUT_EN.
module wb_burst_master #(
    parameter int BURST_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         start_i,
    input  logic                                         write_i,
    input  logic [31:0]                                  line_addr_i,
    input  logic [31:0]                                  wdata_i,
    output logic [((BURST_LEN > 1) ? $clog2(BURST_LEN) : 1)-1:0] windex_o,
    output logic [31:0]                                  rdata_o,
    output logic [((BURST_LEN > 1) ? $clog2(BURST_LEN) : 1)-1:0] rindex_o,
    output logic                                         rvalid_o,
    output logic                                         busy_o,
    output logic                                         done_o,
    output logic                                         err_o,
    output logic [31:0]                                  adr_o,
    output logic [31:0]                                  dat_o,
    output logic [3:0]                                   sel_o,
    output logic                                         we_o,
    output logic                                         cyc_o,
    output logic                                         stb_o,
    output logic [2:0]                                   cti_o,
    output logic [1:0]                                   bte_o,
    input  logic [31:0]                                  dat_i,
    input  logic                                         ack_i
);

    localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BURST_LEN - 1);
    localparam logic [31:0] ALIGN_MASK = ~(32'(BURST_LEN * 4) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE
`ifdef WB_BURST_MASTER_TIMEOUT_EN
        , ABORT
`endif
    } state_t;

    state_t state, state_next;

    logic [31:0]      base;
    logic             dir;
    logic [IDX_W-1:0] beat;
    logic             active;
    logic             accept;
    logic             beat_done;
    logic             last_done;

    assign active    = (state == ACTIVE);
    assign accept    = (state == IDLE) && start_i;
    assign beat_done = active && ack_i;
    assign last_done = beat_done && (beat == LAST_BEAT);
    assign windex_o  = beat;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             err_q;

    assign tmo_hit = active && !ack_i && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err_o   = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_o     = (state != IDLE);
        cyc_o      = 1'b0;
        stb_o      = 1'b0;
        we_o       = 1'b0;
        sel_o      = 4'b0000;
        cti_o      = 3'b000;
        bte_o      = 2'b00;
        adr_o      = 32'd0;
        dat_o      = 32'd0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                we_o  = dir;
                sel_o = 4'b1111;
                cti_o = (beat == LAST_BEAT) ? 3'b111 : 3'b010;
                adr_o = base + (32'(beat) << 2);
                dat_o = dir ? wdata_i : 32'd0;
                if (last_done) begin
                    state_next = IDLE;
                end
`ifdef WB_BURST_MASTER_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_next = ABORT;
                end
`endif
            end
`ifdef WB_BURST_MASTER_TIMEOUT_EN
            ABORT: begin
                state_next = IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Beat sequencing, read capture and the one-cycle completion strobes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            base     <= 32'd0;
            dir      <= 1'b0;
            beat     <= '0;
            rdata_o  <= 32'd0;
            rindex_o <= '0;
            rvalid_o <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            done_o   <= 1'b0;
            if (accept) begin
                base <= line_addr_i & ALIGN_MASK;
                dir  <= write_i;
                beat <= '0;
            end
            if (beat_done) begin
                beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
                if (!dir) begin
                    rdata_o  <= dat_i;
                    rindex_o <= beat;
                    rvalid_o <= 1'b1;
                end
            end
            if (last_done) begin
                done_o <= 1'b1;
            end
`ifdef WB_BURST_MASTER_TIMEOUT_EN
            if (state == ABORT) begin
                done_o <= 1'b1;
            end
`endif
        end
    end

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    // Watchdog restarts on every ack; the error flag survives until the next start.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept || beat_done) begin
                tmo_cnt <= '0;
            end else if (active) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed self-checking bench for wb_burst_master with a word-addressed RAM responder.
// The timeout scenario runs only when WB_BURST_MASTER_TIMEOUT_EN is defined.
module tb_wb_burst_master;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        write_i;
    logic [31:0] line_addr_i;
    logic [31:0] wdata_i;
    logic [1:0]  windex_o;
    logic [31:0] rdata_o;
    logic [1:0]  rindex_o;
    logic        rvalid_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;
    logic [31:0] dat_i;
    logic        ack_i;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:1023];
    logic        ack_en      = 1'b1;
    int          hold_beat   = -1;
    int          hold_cycles = 0;
    int          waited      = 0;

    wb_burst_master #(
        .BURST_LEN      (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .write_i     (write_i),
        .line_addr_i (line_addr_i),
        .wdata_i     (wdata_i),
        .windex_o    (windex_o),
        .rdata_o     (rdata_o),
        .rindex_o    (rindex_o),
        .rvalid_o    (rvalid_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .sel_o       (sel_o),
        .we_o        (we_o),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .cti_o       (cti_o),
        .bte_o       (bte_o),
        .dat_i       (dat_i),
        .ack_i       (ack_i)
    );

    always #5 clk_i = ~clk_i;

    always_comb wdata_i = {4{8'hA0 + 8'(windex_o)}};

    // Responder acks immediately unless the selected beat is being stalled.
    always_comb begin
        dat_i = mem[adr_o[11:2]];
        ack_i = 1'b0;
        if (stb_o && ack_en) begin
            ack_i = (int'(adr_o[3:2]) == hold_beat) ? (waited >= hold_cycles) : 1'b1;
        end
    end

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= (i >= 64 && i < 68) ? 32'h00010203 + 32'h04040404 * 32'(i - 64) : 32'd0;
            end
            waited <= 0;
        end else begin
            waited <= (stb_o && !ack_i) ? waited + 1 : 0;
            if (stb_o && ack_i && we_o) begin
                mem[adr_o[11:2]] <= dat_o;
            end
        end
    end

    task automatic test_reset;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        write_i     = 1'b0;
        line_addr_i = 32'd0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({cyc_o, stb_o, we_o, sel_o, cti_o, bte_o} !== 12'd0) begin
            failures++;
            $display("[TB] FAIL reset_bus got=%h exp=000", {cyc_o, stb_o, we_o, sel_o, cti_o, bte_o});
        end
        checks++;
        if ({busy_o, done_o, rvalid_o, err_o, rindex_o, windex_o} !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_status got=%b exp=00000000", {busy_o, done_o, rvalid_o, err_o, rindex_o, windex_o});
        end
        checks++;
        if ({adr_o, dat_o, rdata_o} !== 96'd0) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h/%h/%h exp=0", adr_o, dat_o, rdata_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({cyc_o, busy_o, done_o} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_idle got=%b exp=000", {cyc_o, busy_o, done_o});
        end
    endtask

    task automatic test_read_burst;
        logic [11:0] exp_bus;
        logic [31:0] exp_data;
        start_i     = 1'b1;
        write_i     = 1'b0;
        line_addr_i = 32'h104;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            exp_bus = {3'b110, 4'hF, (b == 3) ? 3'b111 : 3'b010, 2'b00};
            checks++;
            if ({cyc_o, stb_o, we_o, sel_o, cti_o, bte_o} !== exp_bus) begin
                failures++;
                $display("[TB] FAIL read_bus b=%0d got=%h exp=%h", b, {cyc_o, stb_o, we_o, sel_o, cti_o, bte_o}, exp_bus);
            end
            checks++;
            if (adr_o !== 32'h100 + 32'(4 * b) || dat_o !== 32'd0 || busy_o !== 1'b1) begin
                failures++;
                $display("[TB] FAIL read_adr b=%0d got=%h/%h/%b exp=%h/0/1", b, adr_o, dat_o, busy_o, 32'h100 + 32'(4 * b));
            end
            if (b > 0) begin
                exp_data = 32'h00010203 + 32'h04040404 * 32'(b - 1);
                checks++;
                if ({rvalid_o, rindex_o, rdata_o} !== {1'b1, 2'(b - 1), exp_data}) begin
                    failures++;
                    $display("[TB] FAIL read_data b=%0d got=%b/%0d/%h exp=1/%0d/%h", b, rvalid_o, rindex_o, rdata_o, b - 1, exp_data);
                end
            end else begin
                checks++;
                if (rvalid_o !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL read_rvalid0 got=%b exp=0", rvalid_o);
                end
            end
            @(negedge clk_i);
        end
        checks++;
        if ({cyc_o, stb_o, done_o, busy_o} !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL read_done got=%b exp=0010", {cyc_o, stb_o, done_o, busy_o});
        end
        checks++;
        if ({rvalid_o, rindex_o, rdata_o} !== {1'b1, 2'd3, 32'h0C0D0E0F}) begin
            failures++;
            $display("[TB] FAIL read_last got=%b/%0d/%h exp=1/3/0c0d0e0f", rvalid_o, rindex_o, rdata_o);
        end
        @(negedge clk_i);
        checks++;
        if ({done_o, rvalid_o, cyc_o} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL read_after got=%b exp=000", {done_o, rvalid_o, cyc_o});
        end
    endtask

    task automatic test_write_burst;
        logic [31:0] exp_word;
        start_i     = 1'b1;
        write_i     = 1'b1;
        line_addr_i = 32'h200;
        @(negedge clk_i);
        start_i = 1'b0;
        write_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            exp_word = {4{8'hA0 + 8'(b)}};
            checks++;
            if ({cyc_o, stb_o, we_o, sel_o, cti_o, bte_o} !== {3'b111, 4'hF, (b == 3) ? 3'b111 : 3'b010, 2'b00}) begin
                failures++;
                $display("[TB] FAIL write_bus b=%0d got=%h", b, {cyc_o, stb_o, we_o, sel_o, cti_o, bte_o});
            end
            checks++;
            if (adr_o !== 32'h200 + 32'(4 * b) || dat_o !== exp_word || windex_o !== 2'(b) || rvalid_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL write_beat b=%0d got=%h/%h/%0d/%b exp=%h/%h/%0d/0", b, adr_o, dat_o, windex_o, rvalid_o, 32'h200 + 32'(4 * b), exp_word, b);
            end
            @(negedge clk_i);
        end
        checks++;
        if ({cyc_o, done_o, busy_o, rvalid_o} !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL write_done got=%b exp=0100", {cyc_o, done_o, busy_o, rvalid_o});
        end
        for (int b = 0; b < 4; b++) begin
            exp_word = {4{8'hA0 + 8'(b)}};
            checks++;
            if (mem[128 + b] !== exp_word) begin
                failures++;
                $display("[TB] FAIL write_mem b=%0d got=%h exp=%h", b, mem[128 + b], exp_word);
            end
        end
    endtask

    task automatic test_wait_states;
        logic [31:0] exp_adr [7] = '{32'h100, 32'h104, 32'h108, 32'h108, 32'h108, 32'h108, 32'h10C};
        logic        exp_rv  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp_data;
        int          nrv = 0;
        hold_beat   = 2;
        hold_cycles = 3;
        start_i     = 1'b1;
        write_i     = 1'b0;
        line_addr_i = 32'h10C;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 0; c < 7; c++) begin
            checks++;
            if ({cyc_o, stb_o, we_o, cti_o} !== {3'b110, (c == 6) ? 3'b111 : 3'b010} || adr_o !== exp_adr[c] || dat_o !== 32'd0) begin
                failures++;
                $display("[TB] FAIL wait_bus c=%0d got=%b/%h exp_adr=%h", c, {cyc_o, stb_o, we_o, cti_o}, adr_o, exp_adr[c]);
            end
            checks++;
            if (rvalid_o !== exp_rv[c]) begin
                failures++;
                $display("[TB] FAIL wait_rvalid c=%0d got=%b exp=%b", c, rvalid_o, exp_rv[c]);
            end
            if (exp_rv[c]) begin
                exp_data = 32'h00010203 + 32'h04040404 * 32'(nrv);
                checks++;
                if (rdata_o !== exp_data || rindex_o !== 2'(nrv)) begin
                    failures++;
                    $display("[TB] FAIL wait_data c=%0d got=%h/%0d exp=%h/%0d", c, rdata_o, rindex_o, exp_data, nrv);
                end
                nrv++;
            end
            @(negedge clk_i);
        end
        checks++;
        if ({cyc_o, done_o, rvalid_o, rindex_o} !== 5'b01111 || rdata_o !== 32'h0C0D0E0F) begin
            failures++;
            $display("[TB] FAIL wait_done got=%b/%h exp=01111/0c0d0e0f", {cyc_o, done_o, rvalid_o, rindex_o}, rdata_o);
        end
        hold_beat   = -1;
        hold_cycles = 0;
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid;
        start_i     = 1'b1;
        write_i     = 1'b0;
        line_addr_i = 32'h100;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({cyc_o, stb_o, busy_o, done_o, rvalid_o} !== 5'b00000 || adr_o !== 32'd0) begin
            failures++;
            $display("[TB] FAIL rstmid_state got=%b/%h exp=00000/0", {cyc_o, stb_o, busy_o, done_o, rvalid_o}, adr_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({cyc_o, done_o, rvalid_o} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL rstmid_after got=%b exp=000", {cyc_o, done_o, rvalid_o});
        end
        test_read_burst();
    endtask

    task automatic test_back_to_back;
        int n = 0;
        start_i     = 1'b1;
        write_i     = 1'b0;
        line_addr_i = 32'h100;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        start_i     = 1'b1;
        write_i     = 1'b1;
        line_addr_i = 32'h300;
        @(negedge clk_i);
        start_i = 1'b0;
        write_i = 1'b0;
        checks++;
        if (we_o !== 1'b0 || adr_o !== 32'h108 || cyc_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_ignore got=%b/%h/%b exp=0/108/1", we_o, adr_o, cyc_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({cyc_o, done_o} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL b2b_done1 got=%b exp=01", {cyc_o, done_o});
        end
        start_i     = 1'b1;
        write_i     = 1'b1;
        line_addr_i = 32'h20C;
        @(negedge clk_i);
        start_i = 1'b0;
        write_i = 1'b0;
        checks++;
        if ({cyc_o, we_o, busy_o} !== 3'b111 || adr_o !== 32'h200) begin
            failures++;
            $display("[TB] FAIL b2b_restart got=%b/%h exp=111/200", {cyc_o, we_o, busy_o}, adr_o);
        end
        while (!done_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (done_o !== 1'b1 || n !== 4) begin
            failures++;
            $display("[TB] FAIL b2b_len got=%b/%0d exp=1/4", done_o, n);
        end
        @(negedge clk_i);
        checks++;
        if ({cyc_o, busy_o, done_o} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL b2b_idle got=%b exp=000", {cyc_o, busy_o, done_o});
        end
    endtask

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        int n = 0;
        ack_en      = 1'b0;
        start_i     = 1'b1;
        write_i     = 1'b0;
        line_addr_i = 32'h100;
        @(negedge clk_i);
        start_i = 1'b0;
        while (cyc_o && n < 20) begin
            n++;
            @(negedge clk_i);
        end
        checks++;
        if (n !== 8) begin
            failures++;
            $display("[TB] FAIL tmo_len got=%0d exp=8", n);
        end
        checks++;
        if ({cyc_o, err_o, done_o, busy_o} !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL tmo_abort got=%b exp=0101", {cyc_o, err_o, done_o, busy_o});
        end
        @(negedge clk_i);
        checks++;
        if ({done_o, err_o, busy_o} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL tmo_done got=%b exp=110", {done_o, err_o, busy_o});
        end
        @(negedge clk_i);
        checks++;
        if ({done_o, err_o} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL tmo_hold got=%b exp=01", {done_o, err_o});
        end
        ack_en  = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        checks++;
        if ({err_o, cyc_o} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL tmo_clear got=%b exp=01", {err_o, cyc_o});
        end
        n = 0;
        while (!done_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (done_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tmo_recover got=%b exp=1", done_o);
        end
        @(negedge clk_i);
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        test_reset();
        test_read_burst();
        test_write_burst();
        test_wait_states();
        test_reset_mid();
        test_back_to_back();
`ifdef WB_BURST_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Wishbone B3 initiator that moves one cache-line-sized block of `BURST_LEN` 32-bit words between a core-side line buffer and any Wishbone responder, such as the testbench RAM. It turns a single `start_i` request into an incrementing-address registered-feedback burst, with CTI/BTE signalling. It is the bus-facing end of the cache fill and writeback path.

## Interface
- `BURST_LEN`, 4: words per transfer; power of two, 1..16.
- `TIMEOUT_CYCLES`, 256: ack watchdog limit. Used only when the timeout feature is compiled in.
- `clk_i` in 1: clock. Everything is on the rising edge.
- `rst_ni` in 1: reset. Synchronous, active-low.
- `start_i` in 1: request pulse. Sampled only in IDLE.
- `write_i` in 1: direction, sampled with `start_i`. 1 = write to the bus, 0 = read from the bus.
- `line_addr_i` in 32: byte address of the block, sampled with `start_i`.
- `wdata_i` in 32: write word for index `windex_o`. The core drives it combinationally.
- `windex_o` out log2(BURST_LEN) (min 1): index of the word currently on `dat_o`.
- `rdata_o` out 32: captured read word.
- `rindex_o` out log2(BURST_LEN) (min 1): index of `rdata_o`.
- `rvalid_o` out 1: one-cycle strobe, `rdata_o`/`rindex_o` valid.
- `busy_o` out 1: high from the cycle after an accepted start until `done_o`.
- `done_o` out 1: one-cycle completion strobe.
- `err_o` out 1: timeout flag. Held until the next accepted start. Tied 0 when the feature is out.
- `adr_o` out 32, `dat_o` out 32, `sel_o` out 4, `we_o` out 1, `cyc_o` out 1, `stb_o` out 1, `cti_o` out 3, `bte_o` out 2: Wishbone initiator outputs.
- `dat_i` in 32, `ack_i` in 1: Wishbone responder inputs.

## Operation
- States:
  - IDLE, ACTIVE, and ABORT (ABORT exists only with the timeout feature).
- IDLE:
  - On `start_i`=1, latch the base address as `line_addr_i` with the low log2(BURST_LEN*4) bits forced to 0. Latch `write_i`.
  - Set beat counter to 0 and go to ACTIVE.
  - `start_i` in any other state is ignored. It is not queued.
- ACTIVE outputs:
  - `cyc_o`=`stb_o`=1, `adr_o` = base + 4·beat, `we_o` = latched direction, `sel_o` = 4'b1111, `bte_o` = 2'b00 (linear).
  - `cti_o` = 3'b010 (incrementing) for beat < BURST_LEN-1, and 3'b111 (end of burst) on the last beat. With BURST_LEN=1 the only beat carries 3'b111.
  - Writes: `dat_o` = `wdata_i` and `windex_o` = beat. Reads: `dat_o` = 0.
- Beat completion: a beat completes on an edge where `stb_o`&`ack_i`=1.
  - Reads: `rdata_o` <= `dat_i`, `rindex_o` <= beat, `rvalid_o` pulses the next cycle.
  - The beat counter increments, wrapping to 0 at BURST_LEN.
- Last beat completion:
  - `cyc_o`/`stb_o` drop on the same edge, the state returns to IDLE, and `done_o` pulses for the following cycle.
- `ack_i` with `stb_o`=0 is ignored.
- Address arithmetic is 32-bit modular. A block at 32'hFFFFFFF0 with BURST_LEN=4 stays in range; no carry past bit 31 is checked.
- Reset: every output goes to 0 and the state goes to IDLE at the first edge with `rst_ni`=0, including mid-burst. No `done_o` and no `rvalid_o` are issued for an aborted burst.

## Timing
- Start to bus: `start_i` high at edge N gives `cyc_o`/`stb_o` high from cycle N+1.
- Wait states: each cycle with `stb_o`=1 and `ack_i`=0 holds all bus outputs stable.
- Burst duration: with an ack every cycle, a burst occupies exactly BURST_LEN bus cycles. With a registered-ack responder (first ack one cycle after `stb_o`), it is BURST_LEN+1 cycles from `cyc_o` rise to fall.
- Read data: `rvalid_o` is asserted one cycle after the acking edge.
- Completion: `done_o` is coincident with the first cycle of `cyc_o`=0. `busy_o` falls together with `done_o`.
- Back-to-back: a new `start_i` is accepted in the `done_o` cycle, giving a minimum 1-cycle bus idle gap between bursts.

## Configuration
- `WB_BURST_MASTER_TIMEOUT_EN` defined:
  - A counter clears on every completed beat and increments each ACTIVE cycle without ack.
  - On reaching TIMEOUT_CYCLES it enters ABORT: drop `cyc_o`/`stb_o`, set `err_o`=1, and pulse `done_o` the next cycle.
  - `err_o` clears on the next accepted start.
- Undefined:
  - No counter and no ABORT state. The master waits for ack indefinitely. `err_o` is constant 0.

## Test plan
- Read burst: RAM bytes 0x100..0x10F = 00..0F, start read 0x104 (BURST_LEN=4) -> adr 0x100, 0x104, 0x108, 0x10C. `cti` sequence 010,010,010,111. `rdata` 00010203, 04050607, 08090A0B, 0C0D0E0F with `rindex` 0..3. One `done_o`.
- Write burst: `wdata_i` = {0xA0+idx replicated}, start write 0x200 -> RAM 0x200..0x20F = A0A0A0A0..A3A3A3A3. `sel_o`=1111 throughout.
- Wait states: responder withholds ack for 3 cycles on beat 2 -> `adr_o` = base+8 held, data stable, burst ends 3 cycles later. Order is unchanged.
- Reset mid-burst: `rst_ni`=0 after beat 1 ack -> next edge `cyc_o`=`stb_o`=`busy_o`=0. No `done_o`. A fresh read afterwards returns correct data.
- Start while busy plus back-to-back: `start_i` during ACTIVE is ignored. A start in the `done_o` cycle begins a new burst after exactly one idle cycle.
- Timeout (macro defined, TIMEOUT_CYCLES=8): ack never asserted -> `cyc_o` drops after 8 cycles, `err_o`=1, `done_o` pulses once. The next start clears `err_o`.
